gl_enable_gen: RTL and testbench

GL_ENABLE_GEN -- requirements
Module: gl_enable_gen

---
 rtl/gl_pkg.sv | 17 +
 rtl/gl_enable_gen_if.sv | 34 +++
 rtl/gl_ce_div.sv | 64 ++++++
 rtl/gl_enable_gen.sv | 132 +++++++++++++
 tb/tb_gl_enable_gen.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gl_pkg.sv
// -----------------------------------------------------------------------------
// gl_pkg
// Shared types and constants for the lock-qualified clock-enable generator.
//   gl_state_e : lock qualification state (UNLOCKED / QUALIFY / RUN)
//   GL_MAX_CH  : upper bound on the number of clock-enable channels
// -----------------------------------------------------------------------------
package gl_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_RUN      = 2'd2
  } gl_state_e;

  localparam int GL_MAX_CH = 8;

endpackage

// File: rtl/gl_enable_gen_if.sv
// -----------------------------------------------------------------------------
// gl_enable_gen_if
// Bundles the lock/divider control and the qualified outputs of gl_enable_gen.
//   lock_in : raw CCC lock (asynchronous)
//   div     : packed per-channel divide ratios, channel i at [i*DIV_W +: DIV_W]
//   ch_en   : per-channel run enables
//   locked  : qualified lock
//   rst_out : downstream synchronous reset (complement of locked)
//   ce      : per-channel clock-enable pulses
// master drives the controls and observes the outputs; slave is the generator.
// -----------------------------------------------------------------------------
interface gl_enable_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
) ();

  logic                    lock_in;
  logic [NUM_CH*DIV_W-1:0] div;
  logic [NUM_CH-1:0]       ch_en;
  logic                    locked;
  logic                    rst_out;
  logic [NUM_CH-1:0]       ce;

  modport master (
    output lock_in, div, ch_en,
    input  locked, rst_out, ce
  );

  modport slave (
    input  lock_in, div, ch_en,
    output locked, rst_out, ce
  );

endinterface

// File: rtl/gl_ce_div.sv
// -----------------------------------------------------------------------------
// gl_ce_div
// One clock-enable channel: period counter, latched divide ratio and the
// registered CE pulse.
//   clk : clock
//   rst : asynchronous active-high reset
//   run : global run qualifier (in RUN now and staying in RUN this edge)
//   en  : channel run enable
//   div : requested divide ratio (0 behaves as 1)
//   ce  : one-cycle enable pulse, once every effective divide cycles
// -----------------------------------------------------------------------------
module gl_ce_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] per_cur;
  logic             ce_q, ce_d;

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  always_comb begin
    // A fresh ratio is taken only on the first count of a period, so a ratio
    // change mid-period never shortens or stretches the current pulse spacing.
    per_cur = (cnt_q == '0) ? eff_div(div) : per_q;
    cnt_d   = '0;
    per_d   = per_q;
    ce_d    = 1'b0;
    if (run && en) begin
      per_d = per_cur;
      if (cnt_q == per_cur - DIV_W'(1)) begin
        ce_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // count / ratio / pulse register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      per_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/gl_enable_gen.sv
// -----------------------------------------------------------------------------
// gl_enable_gen
// Qualifies a CCC lock and generates phase-aligned per-channel clock enables.
//   CLK0    : single clock (CCC global output), rising edge
//   ARST    : asynchronous active-high reset
//   LOCK_IN : raw CCC lock, asynchronous to CLK0
//   DIV     : per-channel divide ratios, channel i at [i*DIV_W +: DIV_W]
//   CH_EN   : per-channel run enables
//   LOCKED  : qualified lock, registered, high exactly while in RUN
//   RST_OUT : downstream synchronous reset, complement of LOCKED
//   CE      : per-channel one-cycle clock-enable pulses
// Lock timing: LOCKED rises LOCK_CYCLES+3 edges after the first edge that
// samples LOCK_IN=1 and falls 3 edges after the first edge sampling 0.
// -----------------------------------------------------------------------------
module gl_enable_gen
  import gl_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                    CLK0,
  input  logic                    ARST,
  input  logic                    LOCK_IN,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  input  logic [NUM_CH-1:0]       CH_EN,
  output logic                    LOCKED,
  output logic                    RST_OUT,
  output logic [NUM_CH-1:0]       CE
);

  localparam int            QW     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(LOCK_CYCLES - 1);

  if (NUM_CH < 1 || NUM_CH > GL_MAX_CH) begin : g_num_ch_range
    $error("gl_enable_gen: NUM_CH out of range");
  end

  logic          sync1_q;
  logic          lock_s_q;
  logic          lock_r_q;
  gl_state_e     state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          locked_q, locked_d;
  logic          rst_out_q, rst_out_d;
  logic          run_hold;

  // synchroniser stage: sync1_q -> lock_s_q, then lock_r_q retimes the
  // synchronised lock so gain and loss both land on the required edges
  always_ff @(posedge CLK0 or posedge ARST) begin
    if (ARST) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
      lock_r_q <= 1'b0;
    end else begin
      sync1_q  <= LOCK_IN;
      lock_s_q <= sync1_q;
      lock_r_q <= lock_s_q;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (lock_r_q) begin
          state_d = ST_QUALIFY;
          qcnt_d  = '0;
        end
      end
      ST_QUALIFY: begin
        if (!lock_r_q) begin
          state_d = ST_UNLOCKED;
          qcnt_d  = '0;
        end else if (qcnt_q == Q_LAST) begin
          state_d = ST_RUN;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      ST_RUN: begin
        // no hysteresis: the first low lock sample drops out of RUN
        if (!lock_r_q) begin
          state_d = ST_UNLOCKED;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        qcnt_d  = '0;
      end
    endcase
    locked_d  = (state_d == ST_RUN);
    rst_out_d = ~locked_d;
    // Channels count only while RUN holds across this edge; leaving RUN
    // clears every CE on the same edge LOCKED falls, whatever CH_EN does.
    run_hold  = locked_q & locked_d;
  end

  // state / qualified-output register stage
  always_ff @(posedge CLK0 or posedge ARST) begin
    if (ARST) begin
      state_q   <= ST_UNLOCKED;
      qcnt_q    <= '0;
      locked_q  <= 1'b0;
      rst_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      locked_q  <= locked_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign LOCKED  = locked_q;
  assign RST_OUT = rst_out_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gl_ce_div #(
      .DIV_W (DIV_W)
    ) u_ce_div (
      .clk (CLK0),
      .rst (ARST),
      .run (run_hold),
      .en  (CH_EN[i]),
      .div (DIV[i*DIV_W +: DIV_W]),
      .ce  (CE[i])
    );
  end

endmodule

// File: tb/tb_gl_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_gl_enable_gen
// Bench for gl_enable_gen (NUM_CH=4, DIV_W=16, LOCK_CYCLES=8). Directed
// scenarios use hand-derived edge counts; a randomized run is compared with a
// behavioural model built on run lengths of LOCK_IN samples and absolute
// due-edge scheduling of CE pulses.
// -----------------------------------------------------------------------------
module tb_gl_enable_gen;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int LC     = 8;

  logic clk  = 1'b0;
  logic arst = 1'b1;

  always #5 clk = ~clk;

  gl_enable_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) gif ();

  gl_enable_gen #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .LOCK_CYCLES (LC)
  ) dut (
    .CLK0    (clk),
    .ARST    (arst),
    .LOCK_IN (gif.lock_in),
    .DIV     (gif.div),
    .CH_EN   (gif.ch_en),
    .LOCKED  (gif.locked),
    .RST_OUT (gif.rst_out),
    .CE      (gif.ce)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // LOCKED at edge n is 1 when the samples of LOCK_IN at edges n-LC-3..n-3
  // were all 1, i.e. the run length of ones ending at sample n-3 is > LC.
  // A channel is active on an edge when LOCKED was 1 before and after it and
  // its enable is high; on the first active edge of a period the pulse is
  // scheduled D-1 edges ahead with D taken from DIV at that edge.
  int                rl         = 0;
  int                rl_hist[$] = '{0, 0, 0};
  logic              m_locked   = 1'b0;
  logic [NUM_CH-1:0] m_ce       = '0;
  int                due[NUM_CH];
  int                n_edge     = 0;

  function automatic int div_of(input logic [NUM_CH*DIV_W-1:0] v, input int ch);
    logic [DIV_W-1:0] d;
    d = v[ch*DIV_W +: DIV_W];
    return (d == 0) ? 1 : int'(d);
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      rl       = 0;
      rl_hist  = '{0, 0, 0};
      m_locked = 1'b0;
      m_ce     = '0;
      n_edge   = 0;
      for (int c = 0; c < NUM_CH; c++) due[c] = -1;
    end else begin
      logic was_locked;
      logic active;
      rl = (gif.lock_in === 1'b1) ? ((rl > LC + 1) ? LC + 2 : rl + 1) : 0;
      rl_hist.push_back(rl);
      was_locked = m_locked;
      m_locked   = (rl_hist.pop_front() >= LC + 1);
      for (int c = 0; c < NUM_CH; c++) begin
        active = was_locked && m_locked && (gif.ch_en[c] === 1'b1);
        if (!active) begin
          due[c]  = -1;
          m_ce[c] = 1'b0;
        end else begin
          if (due[c] < 0) due[c] = n_edge + div_of(gif.div, c) - 1;
          m_ce[c] = (n_edge == due[c]);
          if (n_edge == due[c]) due[c] = -1;
        end
      end
      n_edge++;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst        = 1'b1;
    gif.lock_in = 1'b0;
    gif.ch_en   = '0;
    gif.div     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (gif.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", gif.locked); end
    checks++;
    if (gif.rst_out !== 1'b1) begin errors++; $display("FAIL reset_rst_out: got %0b want 1", gif.rst_out); end
    checks++;
    if (gif.ce !== 4'b0000) begin errors++; $display("FAIL reset_ce: got %b want 0000", gif.ce); end
    arst = 1'b0;
  endtask

  // LOCK_IN raised now; edge 0 is the first edge that samples it.
  task automatic test_lock_timing();
    gif.lock_in = 1'b1;
    gif.div     = {16'd5, 16'd3, 16'd1, 16'd0};
    gif.ch_en   = 4'b1111;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (gif.locked !== (k >= 11)) begin
        errors++; $display("FAIL lock_rise_locked edge %0d: got %0b want %0b", k, gif.locked, (k >= 11));
      end
      checks++;
      if (gif.rst_out !== (k < 11)) begin
        errors++; $display("FAIL lock_rise_rst_out edge %0d: got %0b want %0b", k, gif.rst_out, (k < 11));
      end
      checks++;
      if (gif.ce !== 4'b0000) begin
        errors++; $display("FAIL lock_rise_ce edge %0d: got %b want 0000", k, gif.ce);
      end
    end
  endtask

  // Continues right after LOCKED rose; j counts edges after that edge.
  task automatic test_ce_pattern();
    logic [3:0] exp;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      exp = {(j % 5 == 0), (j % 3 == 0), 1'b1, 1'b1};
      checks++;
      if (gif.ce !== exp) begin
        errors++; $display("FAIL ce_pattern +%0d: got %b want %b", j, gif.ce, exp);
      end
    end
  endtask

  task automatic test_div_change();
    logic exp;
    gif.ch_en                   = 4'b0000;
    gif.div[3*DIV_W +: DIV_W]   = 16'd5;
    repeat (2) @(negedge clk);
    gif.ch_en = 4'b1000;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      exp = (k == 4) || (k == 6) || (k == 8) || (k == 10);
      checks++;
      if (gif.ce[3] !== exp) begin
        errors++; $display("FAIL div_change edge %0d: got %0b want %0b", k, gif.ce[3], exp);
      end
      if (k == 1) gif.div[3*DIV_W +: DIV_W] = 16'd2;
    end
  endtask

  task automatic test_ch_toggle();
    logic [3:0] exp;
    gif.div[1*DIV_W +: DIV_W] = 16'd4;
    gif.ch_en                 = 4'b0010;
    repeat (6) @(negedge clk);
    gif.ch_en[1] = 1'b0;
    repeat (2) @(negedge clk);
    gif.ch_en[1] = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      exp = ((k == 3) || (k == 7)) ? 4'b0010 : 4'b0000;
      checks++;
      if (gif.ce !== exp) begin
        errors++; $display("FAIL ch_toggle edge %0d: got %b want %b", k, gif.ce, exp);
      end
    end
  endtask

  task automatic test_lock_loss();
    gif.div   = {16'd5, 16'd3, 16'd1, 16'd0};
    gif.ch_en = 4'b1111;
    repeat (3) @(negedge clk);
    gif.lock_in = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (gif.locked !== (k < 3)) begin
        errors++; $display("FAIL loss_locked edge %0d: got %0b want %0b", k, gif.locked, (k < 3));
      end
      checks++;
      if (gif.rst_out !== (k >= 3)) begin
        errors++; $display("FAIL loss_rst_out edge %0d: got %0b want %0b", k, gif.rst_out, (k >= 3));
      end
      checks++;
      if (gif.ce[0] !== (k < 3)) begin
        errors++; $display("FAIL loss_ce0 edge %0d: got %0b want %0b", k, gif.ce[0], (k < 3));
      end
      if (k >= 3) begin
        checks++;
        if (gif.ce !== 4'b0000) begin
          errors++; $display("FAIL loss_ce edge %0d: got %b want 0000", k, gif.ce);
        end
      end
    end
  endtask

  task automatic test_arst_mid_run();
    gif.lock_in = 1'b1;
    repeat (16) @(negedge clk);
    checks++;
    if (gif.locked !== 1'b1) begin errors++; $display("FAIL arst_pre_locked: got %0b want 1", gif.locked); end
    checks++;
    if (gif.ce[0] !== 1'b1) begin errors++; $display("FAIL arst_pre_ce0: got %0b want 1", gif.ce[0]); end
    #2 arst = 1'b1;
    #1;
    checks++;
    if (gif.locked !== 1'b0) begin errors++; $display("FAIL arst_async_locked: got %0b want 0", gif.locked); end
    checks++;
    if (gif.rst_out !== 1'b1) begin errors++; $display("FAIL arst_async_rst_out: got %0b want 1", gif.rst_out); end
    checks++;
    if (gif.ce !== 4'b0000) begin errors++; $display("FAIL arst_async_ce: got %b want 0000", gif.ce); end
    @(negedge clk);
    arst = 1'b0;
    // requalification from scratch with LOCK_IN held high
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (gif.locked !== (k >= 11)) begin
        errors++; $display("FAIL requalify edge %0d: got %0b want %0b", k, gif.locked, (k >= 11));
      end
    end
  endtask

  task automatic test_glitch();
    gif.lock_in = 1'b0;
    repeat (6) @(negedge clk);
    gif.lock_in = 1'b1;
    repeat (6) @(negedge clk);
    gif.lock_in = 1'b0;
    @(negedge clk);
    gif.lock_in = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (gif.locked !== (k >= 11)) begin
        errors++; $display("FAIL glitch_requalify edge %0d: got %0b want %0b", k, gif.locked, (k >= 11));
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      checks++;
      if (gif.locked !== m_locked) begin
        errors++; $display("FAIL rand_locked cyc %0d: got %0b want %0b", cyc, gif.locked, m_locked);
      end
      checks++;
      if (gif.rst_out !== ~m_locked) begin
        errors++; $display("FAIL rand_rst_out cyc %0d: got %0b want %0b", cyc, gif.rst_out, ~m_locked);
      end
      checks++;
      if (gif.ce !== m_ce) begin
        errors++; $display("FAIL rand_ce cyc %0d: got %b want %b", cyc, gif.ce, m_ce);
      end
      if (gif.lock_in) begin
        if ($urandom_range(0, 99) < 3) begin
          gif.lock_in = 1'b0;
          hold        = $urandom_range(1, 10);
        end
      end else begin
        hold--;
        if (hold <= 0) gif.lock_in = 1'b1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 99) < 4) gif.ch_en[c] = ~gif.ch_en[c];
        if ($urandom_range(0, 99) < 3) gif.div[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 6));
      end
      if (cyc % 997 == 500) begin
        #2 arst = 1'b1;
        #1;
        checks++;
        if ({gif.locked, gif.rst_out, gif.ce} !== 6'b010000) begin
          errors++; $display("FAIL rand_arst cyc %0d: got %b want 010000", cyc, {gif.locked, gif.rst_out, gif.ce});
        end
        @(negedge clk);
        arst = 1'b0;
      end
    end
  endtask

  initial begin
    gif.lock_in = 1'b0;
    gif.ch_en   = '0;
    gif.div     = '0;
    test_reset();
    test_lock_timing();
    test_ce_pattern();
    test_div_change();
    test_ch_toggle();
    test_lock_loss();
    test_arst_mid_run();
    test_glitch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
